program_sequencer: RTL and testbench
====================================

PROGRAM_SEQUENCER -- requirements
Module: program_sequencer

Interface
REQ-001 SHALL have parameter ROM_ADDRESS_WIDTH, default 5, program ROM address width.
REQ-002 SHALL have parameter INPUT_DATA_WIDTH, default 4, opcode width; operand is 2*INPUT_DATA_WIDTH, instruction word is 3*INPUT_DATA_WIDTH.
REQ-003 SHALL use one clock and an asynchronous, active-high reset, with ports clk and reset.
REQ-004 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port run, input, 1, level; free-running execution while high.
REQ-007 SHALL have port step, input, 1, single-cycle pulse; executes one instruction when run is low.
REQ-008 SHALL have port restart, input, 1, pulse; clears the PC to 0 when in IDLE or DONE.
REQ-009 SHALL have port last_addr, input, ROM_ADDRESS_WIDTH, address of the final program instruction.
REQ-010 SHALL have port loop_en, input, 1, wraps to address 0 after last_addr instead of halting.
REQ-011 SHALL have port rom_addr, output, ROM_ADDRESS_WIDTH, registered ROM address, always equal to pc.
REQ-012 SHALL have port rom_data, input, 3*INPUT_DATA_WIDTH, synchronous ROM data valid one cycle after rom_addr; opcode in the top INPUT_DATA_WIDTH bits.
REQ-013 SHALL have port opcode, output, INPUT_DATA_WIDTH, instruction opcode to the execution unit.
REQ-014 SHALL have port operand, output, 2*INPUT_DATA_WIDTH, instruction operand to the execution unit.
REQ-015 SHALL have port start, output, 1, single-cycle execute strobe to the execution unit.
REQ-016 SHALL have port skip_in, input, 1, skip-next request from the datapath (zero test of SNZA/SNZS).
REQ-017 SHALL have port halted, output, 1, high in DONE.
REQ-018 SHALL have port busy, output, 1, high in FETCH, WAIT, ISSUE and SETTLE.

Function
REQ-019 SHALL implement the states IDLE, FETCH, WAIT, ISSUE, SETTLE and DONE.
REQ-020 SHALL move IDLE->FETCH when run=1 or step=1; when both are high, run takes priority and step is ignored.
REQ-021 SHALL perform the following sequence, each transition on one clock edge:
- FETCH->WAIT: ROM access cycle.
- WAIT->ISSUE: latch rom_data into opcode and operand.
- ISSUE->SETTLE: start=1 for exactly this cycle.
- SETTLE: sample skip_in.
REQ-022 SHALL give each instruction a latency of 4 cycles, FETCH entry to SETTLE exit.
REQ-023 SHALL update the PC at SETTLE exit: pc+2 if skip_in=1, else pc+1, computed at ROM_ADDRESS_WIDTH+1 bits.
REQ-024 SHALL treat a next PC greater than last_addr as end of program, including an overshoot caused by a skip.
- loop_en=1: pc=0, and continue if run=1.
- loop_en=0: go to DONE with pc=0.
REQ-025 SHALL, after SETTLE when not at end of program, go to FETCH if run=1, else to IDLE (step mode, or run dropped).
REQ-026 SHALL complete the current instruction through SETTLE when run is deasserted mid-instruction; the PC is retained in IDLE.
REQ-027 SHALL ignore step outside IDLE.
REQ-028 SHALL leave DONE only to IDLE, when run=0; restart in DONE or IDLE sets pc=0.
REQ-029 SHALL hold opcode and operand stable from ISSUE until the next WAIT exit.

Reset
REQ-030 SHALL, on reset assertion at any time including mid-instruction, immediately force: state=IDLE, pc=0, rom_addr=0, opcode=0, operand=0, start=0, halted=0, busy=0.
REQ-031 SHALL, after reset release, issue no start until run or step is sampled high.

Structure
REQ-032 SHALL define the state encoding localparams and the instruction field offsets in the shared CPU package, alongside the opcode definitions used by the instruction decoder.
REQ-033 SHALL contain one sub-module, pc_unit: PC register with increment, skip and wrap logic, selected by loop_en and last_addr.

Verification
REQ-034 SHALL cover linear run: last_addr=3, loop_en=0, run=1, no skips -> start pulses at intervals of 4 cycles with rom_addr 0,1,2,3, then halted=1 and pc=0.
REQ-035 SHALL cover skip: skip_in=1 in SETTLE of address 1 -> next fetch at address 3; address 2 is never issued.
REQ-036 SHALL cover skip overshoot: last_addr=4, skip at 4 with loop_en=1 -> next fetch at 0; with loop_en=0 -> DONE.
REQ-037 SHALL cover step: run=0 with a step pulse -> exactly one start, return to IDLE with pc+1; a second step during busy is ignored.
REQ-038 SHALL cover mid-instruction reset: reset asserted in ISSUE -> start=0 and state IDLE in the same cycle, pc=0 after release.
REQ-039 SHALL cover run drop: run falls during WAIT -> the instruction still issues, then IDLE with pc advanced; run=1 again resumes at that pc.

Source files
------------

// File: rtl/program_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : program_sequencer_pkg
// Brief    : Shared CPU definitions: sequencer state encoding, instruction
//            field layout and the opcode set seen by the instruction decoder.
// Revision : 1.0 - initial release
// ============================================================================
package program_sequencer_pkg;

  // Sequencer state encoding
  localparam int STATE_W = 3;
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_FETCH  = 3'd1;
  localparam logic [2:0] ST_WAIT   = 3'd2;
  localparam logic [2:0] ST_ISSUE  = 3'd3;
  localparam logic [2:0] ST_SETTLE = 3'd4;
  localparam logic [2:0] ST_DONE   = 3'd5;

  // Instruction word layout, in units of the opcode width:
  // [3*W-1 : 2*W] opcode, [2*W-1 : 0] operand.
  localparam int OPERAND_LSB    = 0;
  localparam int OPERAND_FIELDS = 2;
  localparam int OPCODE_FIELD   = 2;   // opcode lsb = OPCODE_FIELD * W
  localparam int WORD_FIELDS    = 3;

  // PC advance amounts
  localparam int PC_STEP      = 1;
  localparam int PC_SKIP_STEP = 2;

  // Opcodes understood by the execution unit's decoder
  typedef enum logic [3:0] {
    OP_NOP  = 4'h0,
    OP_LDA  = 4'h1,
    OP_LDS  = 4'h2,
    OP_ADD  = 4'h3,
    OP_SUB  = 4'h4,
    OP_AND  = 4'h5,
    OP_OR   = 4'h6,
    OP_XOR  = 4'h7,
    OP_SNZA = 4'h8,
    OP_SNZS = 4'h9,
    OP_OUT  = 4'hA
  } opcode_e;

endpackage
`default_nettype wire

// File: rtl/program_sequencer_pc.sv
`default_nettype none
// ============================================================================
// Module   : pc_unit
// Brief    : Program counter with +1 / +2 (skip) advance and end-of-program
//            wrap to zero; flags a halt when looping is disabled.
// Revision : 1.0 - initial release
// ============================================================================
module pc_unit
  import program_sequencer_pkg::*;
#(
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              advance,
  input  logic              skip,
  input  logic              clear,
  input  logic [ADDR_W-1:0] last_addr,
  input  logic              loop_en,
  output logic [ADDR_W-1:0] pc,
  output logic              halt_req
);

  logic [ADDR_W:0] next_pc;
  logic            wrap;

  // One extra bit so a skip past the top of the address space is still seen
  // as an overshoot rather than aliasing back into range.
  always_comb begin
    next_pc  = {1'b0, pc} + (skip ? (ADDR_W+1)'(PC_SKIP_STEP) : (ADDR_W+1)'(PC_STEP));
    wrap     = (next_pc > {1'b0, last_addr});
    halt_req = wrap & ~loop_en;
  end

  // PC register: cleared by restart, advanced once per completed instruction
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc <= '0;
    end else if (clear) begin
      pc <= '0;
    end else if (advance) begin
      pc <= wrap ? '0 : next_pc[ADDR_W-1:0];
    end
  end

endmodule
`default_nettype wire

// File: rtl/program_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : program_sequencer
// Brief    : Fetch / issue sequencer for a small ROM-programmed CPU. Each
//            instruction takes FETCH, WAIT, ISSUE, SETTLE (4 cycles); supports
//            free run, single step, skip-next and looping.
// Revision : 1.0 - initial release
// ============================================================================
module program_sequencer
  import program_sequencer_pkg::*;
#(
  parameter int ROM_ADDRESS_WIDTH = 5,
  parameter int INPUT_DATA_WIDTH  = 4
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            run,
  input  logic                            step,
  input  logic                            restart,
  input  logic [ROM_ADDRESS_WIDTH-1:0]    last_addr,
  input  logic                            loop_en,
  output logic [ROM_ADDRESS_WIDTH-1:0]    rom_addr,
  input  logic [3*INPUT_DATA_WIDTH-1:0]   rom_data,
  output logic [INPUT_DATA_WIDTH-1:0]     opcode,
  output logic [2*INPUT_DATA_WIDTH-1:0]   operand,
  output logic                            start,
  input  logic                            skip_in,
  output logic                            halted,
  output logic                            busy
);

  localparam int OPC_LSB = OPCODE_FIELD * INPUT_DATA_WIDTH;
  localparam int OPR_W   = OPERAND_FIELDS * INPUT_DATA_WIDTH;

  logic [STATE_W-1:0]           state;
  logic [STATE_W-1:0]           state_next;
  logic [ROM_ADDRESS_WIDTH-1:0] pc;
  logic                         halt_req;
  logic                         pc_clear;
  logic                         pc_advance;

  assign pc_clear   = restart && ((state == ST_IDLE) || (state == ST_DONE));
  assign pc_advance = (state == ST_SETTLE);

  pc_unit #(
    .ADDR_W (ROM_ADDRESS_WIDTH)
  ) u_pc (
    .clk       (clk),
    .reset     (reset),
    .advance   (pc_advance),
    .skip      (skip_in),
    .clear     (pc_clear),
    .last_addr (last_addr),
    .loop_en   (loop_en),
    .pc        (pc),
    .halt_req  (halt_req)
  );

  // Next-state selection; run wins over step, step only matters in IDLE
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:   if (run || step) state_next = ST_FETCH;
      ST_FETCH:  state_next = ST_WAIT;
      ST_WAIT:   state_next = ST_ISSUE;
      ST_ISSUE:  state_next = ST_SETTLE;
      ST_SETTLE: begin
        if (halt_req)  state_next = ST_DONE;
        else if (run)  state_next = ST_FETCH;
        else           state_next = ST_IDLE;
      end
      ST_DONE:   if (!run) state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  // Capture the instruction word as it leaves the ROM; held until next WAIT
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      opcode  <= '0;
      operand <= '0;
    end else if (state == ST_WAIT) begin
      opcode  <= rom_data[OPC_LSB +: INPUT_DATA_WIDTH];
      operand <= rom_data[OPERAND_LSB +: OPR_W];
    end
  end

  // Status outputs decode straight from the state register so an async
  // reset drops them in the same cycle.
  assign rom_addr = pc;
  assign start    = (state == ST_ISSUE);
  assign halted   = (state == ST_DONE);
  assign busy     = (state == ST_FETCH) || (state == ST_WAIT) ||
                    (state == ST_ISSUE) || (state == ST_SETTLE);

endmodule
`default_nettype wire

// File: tb/tb_program_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_program_sequencer
// Brief    : Self-checking bench: instruction-level reference model compared
//            every cycle, directed scenarios plus randomized run/step/skip.
// Revision : 1.0 - initial release
// ============================================================================
module tb_program_sequencer;

  localparam int AW = 5;
  localparam int DW = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic            run, step, restart, loop_en, skip_in;
  logic [AW-1:0]   last_addr, rom_addr;
  logic [3*DW-1:0] rom_data;
  logic [DW-1:0]   opcode;
  logic [2*DW-1:0] operand;
  logic            start, halted, busy;

  always #5 clk = ~clk;

  program_sequencer #(
    .ROM_ADDRESS_WIDTH (AW),
    .INPUT_DATA_WIDTH  (DW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .run       (run),
    .step      (step),
    .restart   (restart),
    .last_addr (last_addr),
    .loop_en   (loop_en),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .opcode    (opcode),
    .operand   (operand),
    .start     (start),
    .skip_in   (skip_in),
    .halted    (halted),
    .busy      (busy)
  );

  // Synchronous program ROM
  logic [3*DW-1:0] rom [0:(1<<AW)-1];
  always @(posedge clk) rom_data <= rom[rom_addr];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  int issued_addr[$];
  int issued_cyc[$];

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model. Instruction progress is tracked as "cycles into the
  // current instruction" (0..3), -1 when stopped, 4 when the program ended.
  int              m_phase;
  int              m_pc;
  logic [3*DW-1:0] m_word;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_phase <= -1;
      m_pc    <= 0;
      m_word  <= '0;
    end else if (m_phase == -1) begin
      if (restart)     m_pc    <= 0;
      if (run || step) m_phase <= 0;
    end else if (m_phase == 4) begin
      if (restart) m_pc    <= 0;
      if (!run)    m_phase <= -1;
    end else if (m_phase == 3) begin
      if (m_pc + 1 + int'(skip_in) > int'(last_addr)) begin
        m_pc    <= 0;
        m_phase <= loop_en ? (run ? 0 : -1) : 4;
      end else begin
        m_pc    <= m_pc + 1 + int'(skip_in);
        m_phase <= run ? 0 : -1;
      end
    end else begin
      if (m_phase == 1) m_word <= rom[m_pc];
      m_phase <= m_phase + 1;
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Per-cycle comparison against the model; also logs every issue
  always @(negedge clk) begin
    if (!reset) begin
      chk("rom_addr", rom_addr, m_pc);
      chk("start",    start,    m_phase == 2);
      chk("busy",     busy,     (m_phase >= 0) && (m_phase <= 3));
      chk("halted",   halted,   m_phase == 4);
      chk("opcode",   opcode,   m_word[3*DW-1:2*DW]);
      chk("operand",  operand,  m_word[2*DW-1:0]);
      if (start === 1'b1) begin
        issued_addr.push_back(int'(rom_addr));
        issued_cyc.push_back(cyc);
      end
    end
  end

  // skip_in driver: 0 = never, 1 = when executing skip_at, 2 = random
  int skip_mode = 0;
  int skip_at   = 0;
  always @(negedge clk) begin
    if (skip_mode == 1)      skip_in = (int'(rom_addr) == skip_at);
    else if (skip_mode == 2) skip_in = 1'($urandom_range(0, 1));
    else                     skip_in = 1'b0;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_halted(input string name, input int maxc);
    for (int i = 0; i < maxc && halted !== 1'b1; i++) tick(1);
    chk({name, "_halted"}, halted, 1);
  endtask

  task automatic wait_idle(input string name, input int maxc);
    tick(1);
    for (int i = 0; i < maxc && busy !== 1'b0; i++) tick(1);
    chk({name, "_idle"}, busy, 0);
  endtask

  task automatic wait_start(input string name, input int maxc);
    for (int i = 0; i < maxc && start !== 1'b1; i++) tick(1);
    chk({name, "_start_seen"}, start, 1);
  endtask

  task automatic wait_issues(input string name, input int n, input int maxc);
    for (int i = 0; i < maxc && issued_addr.size() < n; i++) tick(1);
    chk({name, "_issue_count"}, issued_addr.size() >= n, 1);
  endtask

  task automatic check_log(input string name, input int e[$]);
    chk({name, "_len"}, issued_addr.size(), e.size());
    for (int i = 0; i < e.size(); i++)
      chk($sformatf("%s_addr%0d", name, i),
          (i < issued_addr.size()) ? issued_addr[i] : -1, e[i]);
  endtask

  task automatic clear_log();
    issued_addr.delete();
    issued_cyc.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < (1 << AW); i++) rom[i] = 12'($urandom);
    reset = 1'b1; run = 1'b0; step = 1'b0; restart = 1'b0;
    loop_en = 1'b0; last_addr = 5'd3; skip_in = 1'b0;
    tick(2);
    chk("rst_rom_addr", rom_addr, 0);
    chk("rst_start",    start,    0);
    chk("rst_busy",     busy,     0);
    chk("rst_halted",   halted,   0);
    chk("rst_opcode",   opcode,   0);
    chk("rst_operand",  operand,  0);
    reset = 1'b0;
    tick(3);
    chk("post_rst_no_start", issued_addr.size(), 0);

    // Linear run to DONE
    clear_log();
    run = 1'b1;
    wait_halted("linear", 40);
    check_log("linear", '{0, 1, 2, 3});
    for (int i = 1; i < 4; i++)
      chk($sformatf("linear_interval%0d", i),
          (i < issued_cyc.size()) ? issued_cyc[i] - issued_cyc[i-1] : -1, 4);
    chk("linear_done_pc", rom_addr, 0);
    run = 1'b0;
    tick(2);
    chk("linear_left_done", halted, 0);

    // Skip over address 2
    last_addr = 5'd5; skip_mode = 1; skip_at = 1;
    clear_log();
    run = 1'b1;
    wait_halted("skip", 60);
    check_log("skip", '{0, 1, 3, 4, 5});
    run = 1'b0;
    tick(2);

    // Skip overshoot with looping
    last_addr = 5'd4; skip_at = 4; loop_en = 1'b1;
    clear_log();
    run = 1'b1;
    wait_issues("loop", 7, 80);
    run = 1'b0;
    wait_idle("loop", 20);
    check_log("loop", '{0, 1, 2, 3, 4, 0, 1});
    chk("loop_stop_pc", rom_addr, 2);

    // Skip overshoot without looping
    restart = 1'b1; tick(1); restart = 1'b0;
    chk("restart_pc", rom_addr, 0);
    loop_en = 1'b0;
    clear_log();
    run = 1'b1;
    wait_halted("overshoot", 60);
    check_log("overshoot", '{0, 1, 2, 3, 4});
    chk("overshoot_pc", rom_addr, 0);
    run = 1'b0;
    tick(2);

    // Single step, second step while busy is ignored
    skip_mode = 0; last_addr = 5'd10;
    restart = 1'b1; tick(1); restart = 1'b0;
    clear_log();
    step = 1'b1; tick(1); step = 1'b0;
    tick(2);
    step = 1'b1; tick(1); step = 1'b0;
    tick(8);
    check_log("step1", '{0});
    chk("step1_pc", rom_addr, 1);
    chk("step1_idle", busy, 0);
    clear_log();
    step = 1'b1; tick(1); step = 1'b0;
    tick(8);
    check_log("step2", '{1});
    chk("step2_pc", rom_addr, 2);

    // Reset in ISSUE
    run = 1'b1;
    wait_start("midrst", 20);
    #2 reset = 1'b1;
    #1;
    chk("midrst_start",    start,    0);
    chk("midrst_busy",     busy,     0);
    chk("midrst_halted",   halted,   0);
    chk("midrst_rom_addr", rom_addr, 0);
    chk("midrst_opcode",   opcode,   0);
    run = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    clear_log();
    tick(6);
    chk("midrst_no_start", issued_addr.size(), 0);
    chk("midrst_pc", rom_addr, 0);

    // Run dropped during WAIT
    clear_log();
    run = 1'b1;
    wait_start("drop", 20);
    tick(3);
    run = 1'b0;
    wait_idle("drop", 20);
    check_log("drop", '{0, 1});
    chk("drop_pc", rom_addr, 2);
    clear_log();
    run = 1'b1;
    wait_issues("resume", 1, 20);
    chk("resume_addr", (issued_addr.size() > 0) ? issued_addr[0] : -1, 2);
    run = 1'b0;
    wait_idle("resume", 20);

    // Randomized operation, checked every cycle by the model
    skip_mode = 2;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 19) == 0) run = ~run;
      step    = ($urandom_range(0, 7) == 0);
      restart = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 49) == 0) loop_en   = ~loop_en;
      if ($urandom_range(0, 39) == 0) last_addr = 5'($urandom_range(0, 31));
      tick(1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
